vend_ctrl: RTL and testbench
============================

# vend_ctrl

Parametrised vending controller for N item channels. Tracks per-item stock and cumulative spend against an externally supplied money total. Arbitrates buy requests, vends exactly one item per button press, and supports per-channel restock and end-of-transaction spend clear. Sits between the coin/money accumulator and the item dispensers, replacing the fixed four-item purchase block with a synchronous, single-clock design.

## Interface
- N_ITEMS, 4, number of item channels (1..16)
- MONEY_W, 7, width of money, cost, spend and balance values
- STOCK_W, 4, width of each stock counter
- COST, {7'd30,7'd15,7'd10,7'd5}, packed N_ITEMS*MONEY_W; item i cost at [i*MONEY_W +: MONEY_W]
- INIT_STOCK, {4'd1,4'd1,4'd2,4'd6}, packed N_ITEMS*STOCK_W; reset/restock level per item

- Clock  in  1  rising-edge clock for all state
- Reset  in  1  reset, asynchronous, active-high
- Money  in  MONEY_W  total money inserted in the current transaction (unsigned)
- Buy  in  N_ITEMS  level buy buttons, one per item
- Restock  in  N_ITEMS  per-item reload strobe; sampled each edge
- ClearSpent  in  1  end of transaction; zeroes Spent
- Vending  out  N_ITEMS  one-hot, one-cycle dispense pulse
- Denied  out  1  one-cycle pulse: press rejected
- Busy  out  1  controller not in IDLE
- Spent  out  MONEY_W  cumulative cost vended since reset/clear
- Balance  out  MONEY_W  Money − Spent, saturated at 0
- Stock  out  N_ITEMS*STOCK_W  current stock, same packing as INIT_STOCK
- Empty  out  N_ITEMS  bit i = (stock i == 0)

## Operation
- Eligible[i] = Stock[i] != 0 and Balance >= COST[i] and Restock[i] == 0 and ClearSpent == 0.
- Balance is combinational: Money >= Spent ? Money − Spent : 0.
- FSM states: IDLE, VEND, DENY, HOLD.
- IDLE: if Buy == 0, stay. Otherwise select the lowest index i with Buy[i] & Eligible[i]. On a hit, latch Sel = i and go to VEND. With no hit, go to DENY.
- VEND: Vending = onehot(Sel). At the exit edge, Stock[Sel] −= 1 and Spent += COST[Sel]. Then go to HOLD.
  - If Restock[Sel] or ClearSpent is asserted at that edge, the vend still completes. Restock overrides the stock decrement (stock = INIT). ClearSpent overrides the spend add (Spent = 0).
- DENY: Denied = 1 for one cycle, then go to HOLD.
- HOLD: stay until Buy == 0, then go to IDLE. Exactly one vend or deny happens per press, and held or extra buttons are ignored.
- Restock[i] loads INIT_STOCK[i] into stock i at any state.
- ClearSpent loads 0 into Spent at any state.
- Spent addition is MONEY_W wide. Because of the eligibility check, a vend never overflows while Money is stable.
- Reset values: state IDLE, Vending 0, Denied 0, Busy 0, Spent 0, Stock = INIT_STOCK, Empty derived, Balance = Money.
- Reset mid-VEND aborts the vend: no decrement and no spend.

## Timing
- Buy is sampled at edge k. Vending or Denied is high from edge k to edge k+1.
- Stock and Spent update at edge k+1. Busy is high from edge k until the edge after Buy falls in HOLD.
- Minimum press-to-press period is 3 cycles: IDLE→VEND→HOLD→IDLE.
- Buy requires no synchronisation inside the block; the upstream debouncer provides synchronous inputs.
- All outputs except Balance, Empty and Busy-derived values are registered or decoded from registers only.

## Test plan
- Reset, Money=20, Buy=0001 for 3 cycles: one Vending=0001 pulse, Stock0 6→5, Spent=5, Balance=15, Denied never asserted.
- Money=12, Buy=1110: item 1 is eligible (10 ≤ 12), items 2/3 are not. Expect Vending=0010, Spent=10, Balance=2. The next press of Buy=0010 gives a Denied pulse and no state change.
- Drain item 2 (stock 1), then press item 2 again with Money=100: Denied pulse, Empty[2]=1. Pulse Restock[2], then press: vend succeeds, stock 1→0.
- Restock[0] asserted at the VEND exit edge for item 0: Vending pulses, Spent += 5, Stock0 = 6 (not 5).
- ClearSpent during HOLD: Spent→0, Balance=Money. Assert Reset during VEND: Stock and Spent revert to INIT/0, Vending drops immediately.
- Parameter override N_ITEMS=6, MONEY_W=8, arbitrary COST: simultaneous Buy on items 3 and 5, both eligible, gives Vending=001000.

Source files
------------

// File: rtl/vend_ctrl.sv
// vend_ctrl: synchronous vending controller for N_ITEMS item channels.
//
// Tracks per-item stock and the cumulative spend against an externally
// supplied money total. One buy press results in exactly one vend or one
// deny. Buttons that are held or pressed in addition to the first are
// ignored until every button is released.
//
// Ports
//   Clock       in   rising-edge clock for all state
//   Reset       in   asynchronous, active-high reset
//   Money       in   total money inserted in the current transaction
//   Buy         in   level buy buttons, one per item
//   Restock     in   per-item reload strobe (stock <= INIT_STOCK)
//   ClearSpent  in   end of transaction, zeroes Spent
//   Vending     out  one-hot, one-cycle dispense pulse (registered)
//   Denied      out  one-cycle pulse when a press is rejected (registered)
//   Busy        out  controller not in IDLE (registered)
//   Spent       out  cumulative cost vended since reset/clear (registered)
//   Balance     out  Money - Spent, saturated at 0 (combinational)
//   Stock       out  packed per-item stock (registered)
//   Empty       out  bit i set when stock i is zero (decoded from Stock)
module vend_ctrl #(
    parameter int N_ITEMS = 4,
    parameter int MONEY_W = 7,
    parameter int STOCK_W = 4,
    parameter logic [N_ITEMS*MONEY_W-1:0] COST       = {7'd30, 7'd15, 7'd10, 7'd5},
    parameter logic [N_ITEMS*STOCK_W-1:0] INIT_STOCK = {4'd1, 4'd1, 4'd2, 4'd6}
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [MONEY_W-1:0]           Money,
    input  logic [N_ITEMS-1:0]           Buy,
    input  logic [N_ITEMS-1:0]           Restock,
    input  logic                         ClearSpent,
    output logic [N_ITEMS-1:0]           Vending,
    output logic                         Denied,
    output logic                         Busy,
    output logic [MONEY_W-1:0]           Spent,
    output logic [MONEY_W-1:0]           Balance,
    output logic [N_ITEMS*STOCK_W-1:0]   Stock,
    output logic [N_ITEMS-1:0]           Empty
);

    localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VEND = 2'd1,
        ST_DENY = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [SEL_W-1:0]             sel_q, sel_d;
    logic [N_ITEMS-1:0]           vending_q, vending_d;
    logic                         denied_q, denied_d;
    logic                         busy_q, busy_d;
    logic [MONEY_W-1:0]           spent_q, spent_d;
    logic [N_ITEMS*STOCK_W-1:0]   stock_q, stock_d;

    logic [MONEY_W-1:0]           balance_s;
    logic [N_ITEMS-1:0]           eligible_s;
    logic [N_ITEMS-1:0]           req_s;
    logic                         hit_s;
    logic [SEL_W-1:0]             hit_idx_s;
    logic [MONEY_W-1:0]           sel_cost_s;

    // Balance saturates at zero so a Money drop never wraps around.
    always_comb begin
        if (Money >= spent_q) begin
            balance_s = Money - spent_q;
        end else begin
            balance_s = {MONEY_W{1'b0}};
        end
    end

    // Per-item eligibility; a reload or clear in the same cycle blocks the
    // purchase so stock/spend never see two conflicting updates at once.
    always_comb begin
        eligible_s = {N_ITEMS{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
            eligible_s[i] = (stock_q[i*STOCK_W +: STOCK_W] != {STOCK_W{1'b0}})
                          && (balance_s >= COST[i*MONEY_W +: MONEY_W])
                          && !Restock[i]
                          && !ClearSpent;
        end
    end

    // Lowest-index eligible request wins: scanning downward lets the lowest
    // hit overwrite any higher one.
    always_comb begin
        req_s     = Buy & eligible_s;
        hit_s     = |req_s;
        hit_idx_s = {SEL_W{1'b0}};
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            hit_idx_s = req_s[i] ? SEL_W'(i) : hit_idx_s;
        end
    end

    // Cost of the latched selection, used for the spend update at VEND exit.
    always_comb begin
        sel_cost_s = {MONEY_W{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
            sel_cost_s = (sel_q == SEL_W'(i)) ? COST[i*MONEY_W +: MONEY_W] : sel_cost_s;
        end
    end

    // FSM next state and next values of the registered pulse outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        vending_d = {N_ITEMS{1'b0}};
        denied_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Buy != {N_ITEMS{1'b0}}) begin
                    if (hit_s) begin
                        sel_d   = hit_idx_s;
                        state_d = ST_VEND;
                        for (int i = 0; i < N_ITEMS; i++) begin
                            vending_d[i] = (hit_idx_s == SEL_W'(i));
                        end
                    end else begin
                        state_d  = ST_DENY;
                        denied_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VEND: state_d = ST_HOLD;
            ST_DENY: state_d = ST_HOLD;
            ST_HOLD: begin
                if (Buy == {N_ITEMS{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Spend update: clear has priority over the add so a vend finishing on
    // the clear edge leaves Spent at zero.
    always_comb begin
        if (ClearSpent) begin
            spent_d = {MONEY_W{1'b0}};
        end else if (state_q == ST_VEND) begin
            spent_d = spent_q + sel_cost_s;
        end else begin
            spent_d = spent_q;
        end
    end

    // Stock update: restock has priority over the vend decrement.
    always_comb begin
        stock_d = stock_q;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (Restock[i]) begin
                stock_d[i*STOCK_W +: STOCK_W] = INIT_STOCK[i*STOCK_W +: STOCK_W];
            end else if ((state_q == ST_VEND) && (sel_q == SEL_W'(i))) begin
                stock_d[i*STOCK_W +: STOCK_W] = stock_q[i*STOCK_W +: STOCK_W] - STOCK_W'(1);
            end else begin
                stock_d[i*STOCK_W +: STOCK_W] = stock_q[i*STOCK_W +: STOCK_W];
            end
        end
    end

    // State and output registers; reset aborts any vend in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= {SEL_W{1'b0}};
            vending_q <= {N_ITEMS{1'b0}};
            denied_q  <= 1'b0;
            busy_q    <= 1'b0;
            spent_q   <= {MONEY_W{1'b0}};
            stock_q   <= INIT_STOCK;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            vending_q <= vending_d;
            denied_q  <= denied_d;
            busy_q    <= busy_d;
            spent_q   <= spent_d;
            stock_q   <= stock_d;
        end
    end

    // Empty flags decoded from the stock registers.
    always_comb begin
        Empty = {N_ITEMS{1'b0}};
        for (int i = 0; i < N_ITEMS; i++) begin
            Empty[i] = (stock_q[i*STOCK_W +: STOCK_W] == {STOCK_W{1'b0}});
        end
    end

    assign Vending = vending_q;
    assign Denied  = denied_q;
    assign Busy    = busy_q;
    assign Spent   = spent_q;
    assign Stock   = stock_q;
    assign Balance = balance_s;

endmodule

// File: tb/tb_vend_ctrl.sv
// Testbench for vend_ctrl: scenario tasks push the expected vend/deny events
// into a queue when the press is driven; a negedge monitor pops and compares
// whenever the DUT emits a pulse. Stock/spend/balance are checked inline.
module tb_vend_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  money;
    logic [3:0]  buy, restock;
    logic        clr;
    logic [3:0]  vending;
    logic        denied, busy;
    logic [6:0]  spent, balance;
    logic [15:0] stock;
    logic [3:0]  empty;

    // Second instance with overridden parameters
    logic [7:0]  money2;
    logic [5:0]  buy2, vending2, empty2;
    logic        denied2, busy2;
    logic [7:0]  spent2, balance2;
    logic [23:0] stock2;

    typedef struct packed {
        logic [3:0] vend;
        logic       den;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vend_ctrl dut (
        .Clock(clk), .Reset(rst), .Money(money), .Buy(buy), .Restock(restock),
        .ClearSpent(clr), .Vending(vending), .Denied(denied), .Busy(busy),
        .Spent(spent), .Balance(balance), .Stock(stock), .Empty(empty)
    );

    vend_ctrl #(
        .N_ITEMS(6), .MONEY_W(8), .STOCK_W(4),
        .COST({8'd40, 8'd20, 8'd30, 8'd25, 8'd12, 8'd9}),
        .INIT_STOCK(24'h333333)
    ) dut_p (
        .Clock(clk), .Reset(rst), .Money(money2), .Buy(buy2), .Restock(6'b000000),
        .ClearSpent(1'b0), .Vending(vending2), .Denied(denied2), .Busy(busy2),
        .Spent(spent2), .Balance(balance2), .Stock(stock2), .Empty(empty2)
    );

    // Scoreboard monitor: every observed pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ((vending != 4'b0000) || denied)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: vending=%b denied=%b, required none", vending, denied);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ((vending !== e.vend) || (denied !== e.den)) begin
                    n_errors++;
                    $display("FAIL pulse: vending=%b denied=%b, required vending=%b denied=%b",
                             vending, denied, e.vend, e.den);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    // Press, hold for 'hold' cycles, release and wait until back in IDLE.
    task automatic press(input logic [3:0] b, input int hold, input logic [3:0] ev, input logic dn);
        exp_q.push_back('{vend: ev, den: dn});
        buy = b;
        cyc(hold);
        buy = 4'b0000;
        cyc(2);
    endtask

    task automatic test_reset();
        money = 7'd20; buy = 4'b0000; restock = 4'b0000; clr = 1'b0;
        money2 = 8'd0; buy2 = 6'b000000;
        rst = 1'b1;
        cyc(2);
        n_checks++; if (vending !== 4'b0000) begin n_errors++; $display("FAIL rst_vending: got %b want 0000", vending); end
        n_checks++; if (denied !== 1'b0) begin n_errors++; $display("FAIL rst_denied: got %b want 0", denied); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (spent !== 7'd0) begin n_errors++; $display("FAIL rst_spent: got %0d want 0", spent); end
        n_checks++; if (stock !== 16'h1126) begin n_errors++; $display("FAIL rst_stock: got %h want 1126", stock); end
        n_checks++; if (empty !== 4'b0000) begin n_errors++; $display("FAIL rst_empty: got %b want 0000", empty); end
        n_checks++; if (balance !== 7'd20) begin n_errors++; $display("FAIL rst_balance: got %0d want 20", balance); end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_basic();
        money = 7'd20;
        exp_q.push_back('{vend: 4'b0001, den: 1'b0});
        buy = 4'b0001;
        cyc(1);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        cyc(2);
        buy = 4'b0000;
        cyc(2);
        n_checks++; if (stock[3:0] !== 4'd5) begin n_errors++; $display("FAIL basic_stock0: got %0d want 5", stock[3:0]); end
        n_checks++; if (spent !== 7'd5) begin n_errors++; $display("FAIL basic_spent: got %0d want 5", spent); end
        n_checks++; if (balance !== 7'd15) begin n_errors++; $display("FAIL basic_balance: got %0d want 15", balance); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_priority();
        apply_reset();
        money = 7'd12;
        press(4'b1110, 1, 4'b0010, 1'b0);
        n_checks++; if (spent !== 7'd10) begin n_errors++; $display("FAIL prio_spent: got %0d want 10", spent); end
        n_checks++; if (balance !== 7'd2) begin n_errors++; $display("FAIL prio_balance: got %0d want 2", balance); end
        n_checks++; if (stock !== 16'h1116) begin n_errors++; $display("FAIL prio_stock: got %h want 1116", stock); end
        press(4'b0010, 1, 4'b0000, 1'b1);
        n_checks++; if (spent !== 7'd10) begin n_errors++; $display("FAIL deny_spent: got %0d want 10", spent); end
        n_checks++; if (stock !== 16'h1116) begin n_errors++; $display("FAIL deny_stock: got %h want 1116", stock); end
    endtask

    task automatic test_empty_restock();
        apply_reset();
        money = 7'd100;
        press(4'b0100, 1, 4'b0100, 1'b0);
        n_checks++; if (stock[11:8] !== 4'd0) begin n_errors++; $display("FAIL drain_stock2: got %0d want 0", stock[11:8]); end
        press(4'b0100, 1, 4'b0000, 1'b1);
        n_checks++; if (empty !== 4'b0100) begin n_errors++; $display("FAIL empty_flag: got %b want 0100", empty); end
        restock = 4'b0100;
        cyc(1);
        restock = 4'b0000;
        n_checks++; if (stock[11:8] !== 4'd1) begin n_errors++; $display("FAIL restock2: got %0d want 1", stock[11:8]); end
        press(4'b0100, 1, 4'b0100, 1'b0);
        n_checks++; if (stock[11:8] !== 4'd0) begin n_errors++; $display("FAIL revend_stock2: got %0d want 0", stock[11:8]); end
        n_checks++; if (spent !== 7'd30) begin n_errors++; $display("FAIL revend_spent: got %0d want 30", spent); end
    endtask

    task automatic test_restock_at_vend();
        apply_reset();
        money = 7'd20;
        exp_q.push_back('{vend: 4'b0001, den: 1'b0});
        buy = 4'b0001;
        cyc(1);
        restock = 4'b0001;
        buy = 4'b0000;
        cyc(1);
        restock = 4'b0000;
        cyc(1);
        n_checks++; if (stock[3:0] !== 4'd6) begin n_errors++; $display("FAIL rsv_stock0: got %0d want 6", stock[3:0]); end
        n_checks++; if (spent !== 7'd5) begin n_errors++; $display("FAIL rsv_spent: got %0d want 5", spent); end
    endtask

    task automatic test_clear_and_reset_vend();
        money = 7'd50;
        exp_q.push_back('{vend: 4'b0001, den: 1'b0});
        buy = 4'b0001;
        cyc(3);
        n_checks++; if (spent !== 7'd10) begin n_errors++; $display("FAIL pre_clear_spent: got %0d want 10", spent); end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        n_checks++; if (spent !== 7'd0) begin n_errors++; $display("FAIL clear_spent: got %0d want 0", spent); end
        n_checks++; if (balance !== 7'd50) begin n_errors++; $display("FAIL clear_balance: got %0d want 50", balance); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL clear_busy: got %b want 1", busy); end
        buy = 4'b0000;
        cyc(2);
        // Reset while the vend pulse is high
        money = 7'd20;
        exp_q.push_back('{vend: 4'b0001, den: 1'b0});
        buy = 4'b0001;
        cyc(1);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (vending !== 4'b0000) begin n_errors++; $display("FAIL rstv_vending: got %b want 0000", vending); end
        n_checks++; if (stock !== 16'h1126) begin n_errors++; $display("FAIL rstv_stock: got %h want 1126", stock); end
        n_checks++; if (spent !== 7'd0) begin n_errors++; $display("FAIL rstv_spent: got %0d want 0", spent); end
        buy = 4'b0000;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        n_checks++; if (stock !== 16'h1126) begin n_errors++; $display("FAIL rstv_stock_after: got %h want 1126", stock); end
    endtask

    task automatic test_param_override();
        money2 = 8'd100;
        buy2 = 6'b101000;
        cyc(1);
        n_checks++; if (vending2 !== 6'b001000) begin n_errors++; $display("FAIL param_vending: got %b want 001000", vending2); end
        buy2 = 6'b000000;
        cyc(2);
        n_checks++; if (spent2 !== 8'd30) begin n_errors++; $display("FAIL param_spent: got %0d want 30", spent2); end
        n_checks++; if (stock2 !== 24'h332333) begin n_errors++; $display("FAIL param_stock: got %h want 332333", stock2); end
        n_checks++; if (balance2 !== 8'd70) begin n_errors++; $display("FAIL param_balance: got %0d want 70", balance2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_empty_restock();
        test_restock_at_vend();
        test_clear_and_reset_vend();
        test_param_override();
        cyc(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
